// File: rtl/serial_bit_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_bit_feeder_if
//  Purpose  : Load handshake and serial-output bundle for serial_bit_feeder.
//             master = upstream word source / observer, slave = the feeder.
//  Signals  : data_in, load_valid (to feeder); load_ready, w_out, bit_valid,
//             last_bit, done, busy (from feeder)
//  Revision : 1.0  initial release
// ============================================================================
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             w_out;
    logic             bit_valid;
    logic             last_bit;
    logic             done;
    logic             busy;

    modport master (
        output data_in, load_valid,
        input  load_ready, w_out, bit_valid, last_bit, done, busy
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, w_out, bit_valid, last_bit, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_bit_feeder
//  Purpose  : Parallel-to-serial front end for the two-consecutive-ones
//             detector. Accepts a WIDTH-bit word over valid/ready, shifts it
//             out one bit per clock on w_out, then holds w_out low for
//             GAP_CYCLES so ones of adjacent words never form a false pair.
//  Ports    : clk   - rising-edge clock
//             reset - synchronous active-high reset
//             bus   - serial_bit_feeder_if.slave (load handshake + strobes)
//  Revision : 1.0  initial release
// ============================================================================
module serial_bit_feeder #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    serial_bit_feeder_if.slave bus
);

    localparam int            CW            = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_CNT_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_PENULT  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0] r_shift,     w_shift_nxt;
    logic [CW-1:0]    r_cnt,       w_cnt_nxt;
    logic             r_w_out,     w_w_out_nxt;
    logic             r_bit_valid, w_bit_valid_nxt;
    logic             r_last_bit,  w_last_bit_nxt;
    logic             r_done,      w_done_nxt;

    logic             w_accept;
    logic             w_gap_end;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_load_rest;
    logic [WIDTH-1:0] w_shift_adv;

    assign w_accept = bus.load_valid && (r_state == S_IDLE);

    // The first bit is registered straight onto w_out at the accept edge, so
    // the shift register only ever holds the bits still to be presented.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_first_bit = bus.data_in[WIDTH-1];
            assign w_load_rest = bus.data_in << 1;
            assign w_next_bit  = r_shift[WIDTH-1];
            assign w_shift_adv = r_shift << 1;
        end else begin : g_lsb_first
            assign w_first_bit = bus.data_in[0];
            assign w_load_rest = bus.data_in >> 1;
            assign w_next_bit  = r_shift[0];
            assign w_shift_adv = r_shift >> 1;
        end
    endgenerate

    // Gap counter exists only when there is a gap to time.
    generate
        if (GAP_CYCLES > 0) begin : g_gap
            localparam int            GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
            localparam logic [GW-1:0] c_GAP_LAST = GW'(GAP_CYCLES - 1);

            logic [GW-1:0] r_gap_cnt;

            // Held at zero outside GAP so each gap starts counting from 0.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_gap_cnt <= '0;
                end else if ((r_state == S_GAP) && (r_gap_cnt != c_GAP_LAST)) begin
                    r_gap_cnt <= r_gap_cnt + GW'(1);
                end else begin
                    r_gap_cnt <= '0;
                end
            end

            assign w_gap_end = (r_gap_cnt == c_GAP_LAST);
        end else begin : g_no_gap
            assign w_gap_end = 1'b1;
        end
    endgenerate

    // Next-state and next-output logic. Every registered output defaults to
    // its idle value, so strobes are single-cycle unless re-asserted.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_w_out_nxt     = 1'b0;
        w_bit_valid_nxt = 1'b0;
        w_last_bit_nxt  = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = S_SHIFT;
                    w_shift_nxt     = w_load_rest;
                    w_cnt_nxt       = '0;
                    w_w_out_nxt     = w_first_bit;
                    w_bit_valid_nxt = 1'b1;
                end
            end

            S_SHIFT: begin
                // r_cnt is the index of the bit currently on w_out.
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt       = r_cnt + CW'(1);
                    w_shift_nxt     = w_shift_adv;
                    w_w_out_nxt     = w_next_bit;
                    w_bit_valid_nxt = 1'b1;
                    w_last_bit_nxt  = (r_cnt == c_CNT_PENULT);
                end
            end

            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_w_out     <= 1'b0;
            r_bit_valid <= 1'b0;
            r_last_bit  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_w_out     <= w_w_out_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_last_bit  <= w_last_bit_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.w_out      = r_w_out;
    assign bus.bit_valid  = r_bit_valid;
    assign bus.last_bit   = r_last_bit;
    assign bus.done       = r_done;
    assign bus.load_ready = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_bit_feeder
//  Purpose  : Self-checking bench for serial_bit_feeder. Three instances:
//             A (MSB-first, gap 2), B (MSB-first, gap 0), C (LSB-first,
//             gap 2). Expected bit streams are queued at each accept and
//             popped whenever a feeder presents a valid bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_bit_feeder;

    logic       clk;
    logic       rst;
    logic [2:0] valid;
    logic [7:0] din [3];
    logic       armed;

    int checks = 0;
    int errors = 0;

    serial_bit_feeder_if #(.WIDTH(8)) ifa ();
    serial_bit_feeder_if #(.WIDTH(8)) ifb ();
    serial_bit_feeder_if #(.WIDTH(8)) ifc ();

    assign ifa.load_valid = valid[0];
    assign ifb.load_valid = valid[1];
    assign ifc.load_valid = valid[2];
    assign ifa.data_in    = din[0];
    assign ifb.data_in    = din[1];
    assign ifc.data_in    = din[2];

    serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
    serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) dut_b (.clk(clk), .reset(rst), .bus(ifb));
    serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b0)) dut_c (.clk(clk), .reset(rst), .bus(ifc));

    wire [2:0] rdy = {ifc.load_ready, ifb.load_ready, ifa.load_ready};
    wire [2:0] bv  = {ifc.bit_valid,  ifb.bit_valid,  ifa.bit_valid};
    wire [2:0] wo  = {ifc.w_out,      ifb.w_out,      ifa.w_out};
    wire [2:0] lb  = {ifc.last_bit,   ifb.last_bit,   ifa.last_bit};
    wire [2:0] dn  = {ifc.done,       ifb.done,       ifa.done};
    wire [2:0] bz  = {ifc.busy,       ifb.busy,       ifa.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues of expected serial bits, one per instance.
    logic qa[$];
    logic qb[$];
    logic qc[$];
    int   zc    [3];
    logic prevw [3];

    function automatic int qsize(input int d);
        case (d)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic push_stream(input int d, input logic [7:0] s);
        for (int i = 7; i >= 0; i--) begin
            case (d)
                0:       qa.push_back(s[i]);
                1:       qb.push_back(s[i]);
                default: qc.push_back(s[i]);
            endcase
        end
    endtask

    // Monitor: compares each valid bit against the queue, checks w_out is low
    // on non-valid cycles, and runs a two-ones detector (z = w & w_prev).
    always @(negedge clk) begin : mon
        logic e;
        bit   have;
        if (armed) begin
            for (int d = 0; d < 3; d++) begin
                if (bv[d]) begin
                    have = 1'b1;
                    e    = 1'b0;
                    case (d)
                        0:       if (qa.size() > 0) e = qa.pop_front(); else have = 1'b0;
                        1:       if (qb.size() > 0) e = qb.pop_front(); else have = 1'b0;
                        default: if (qc.size() > 0) e = qc.pop_front(); else have = 1'b0;
                    endcase
                    if (!have) chk($sformatf("unexpected_bit_dut%0d", d), 32'd1, 32'd0);
                    else       chk($sformatf("serial_bit_dut%0d", d), {31'd0, wo[d]}, {31'd0, e});
                end else begin
                    chk($sformatf("idle_wout_dut%0d", d), {31'd0, wo[d]}, 32'd0);
                end
                zc[d]    = zc[d] + int'(wo[d] & prevw[d]);
                prevw[d] = wo[d];
            end
        end
    end

    // Offer a word, wait (bounded) for acceptance, queue the expected stream.
    // Returns just after the accept edge, i.e. inside cycle N+1.
    task automatic send(input int d, input logic [7:0] v, input logic [7:0] s);
        int t;
        t = 0;
        @(negedge clk);
        din[d]   = v;
        valid[d] = 1'b1;
        while (!rdy[d] && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("load_accept_timeout", {31'd0, (t < 60)}, 32'd1);
        @(posedge clk);
        push_stream(d, s);
        #1;
        valid[d] = 1'b0;
        zc[d]    = 0;
    endtask

    task automatic wait_done(input int d);
        int t;
        t = 0;
        while (!dn[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", {31'd0, (t < 50)}, 32'd1);
        repeat (4) @(negedge clk);
        chk("queue_drained", qsize(d), 32'd0);
    endtask

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic [7:0] stream;   // expected serial order, bit 7 = first out
        int         pairs;    // expected detector z pulses for the word
    } vec_t;

    vec_t vecs [8];

    initial begin : main
        int dcount;

        vecs[0] = '{0, 8'hB6, 8'b10110110, 2};
        vecs[1] = '{0, 8'h81, 8'b10000001, 0};
        vecs[2] = '{0, 8'hC3, 8'b11000011, 2};
        vecs[3] = '{0, 8'hFF, 8'b11111111, 7};
        vecs[4] = '{2, 8'hB6, 8'b01101101, 2};
        vecs[5] = '{2, 8'h01, 8'b10000000, 0};
        vecs[6] = '{1, 8'hFF, 8'b11111111, 7};
        vecs[7] = '{1, 8'h01, 8'b00000001, 0};

        armed = 1'b0;
        rst   = 1'b1;
        valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            din[i]   = 8'h00;
            zc[i]    = 0;
            prevw[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("reset_w_out",     {31'd0, wo[0]}, 32'd0);
        chk("reset_bit_valid", {31'd0, bv[0]}, 32'd0);
        chk("reset_last_bit",  {31'd0, lb[0]}, 32'd0);
        chk("reset_done",      {31'd0, dn[0]}, 32'd0);
        chk("reset_busy",      {29'd0, bz},    32'd0);
        chk("reset_ready",     {29'd0, rdy},   32'd7);
        armed = 1'b1;

        // Table-driven words
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].dut, vecs[i].data, vecs[i].stream);
            wait_done(vecs[i].dut);
            chk($sformatf("z_pairs_vec%0d", i), zc[vecs[i].dut], vecs[i].pairs);
        end

        // Strobe timing for one word on A (cycle k = N+k)
        send(0, 8'hB6, 8'b10110110);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk($sformatf("tim_last_bit_k%0d", k),  {31'd0, lb[0]},  {31'd0, (k == 8)});
            chk($sformatf("tim_done_k%0d", k),      {31'd0, dn[0]},  {31'd0, (k == 9)});
            chk($sformatf("tim_bit_valid_k%0d", k), {31'd0, bv[0]},  {31'd0, (k <= 8)});
            chk($sformatf("tim_ready_k%0d", k),     {31'd0, rdy[0]}, {31'd0, (k == 11)});
            chk($sformatf("tim_busy_k%0d", k),      {31'd0, bz[0]},  {31'd0, (k != 11)});
        end
        chk("tim_z_pairs", zc[0], 32'd2);

        // Back-to-back on B (no gap): held valid, second word starts at N+10
        @(negedge clk);
        din[1]   = 8'hFF;
        valid[1] = 1'b1;
        chk("b2b_ready_idle", {31'd0, rdy[1]}, 32'd1);
        @(posedge clk);
        push_stream(1, 8'hFF);
        #1 din[1] = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 8) chk($sformatf("b2b_ready_low_k%0d", k), {31'd0, rdy[1]}, 32'd0);
            if (k == 9) begin
                chk("b2b_done_k9",  {31'd0, dn[1]},  32'd1);
                chk("b2b_ready_k9", {31'd0, rdy[1]}, 32'd1);
                @(posedge clk);
                push_stream(1, 8'b00000001);
                #1 valid[1] = 1'b0;
            end
            if (k == 10) chk("b2b_second_first_bit_k10", {31'd0, bv[1]}, 32'd1);
        end
        wait_done(1);

        // Load attempt while busy on A is ignored
        send(0, 8'hB6, 8'b10110110);
        dcount = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (dn[0]) dcount++;
            if (k == 3) begin
                din[0]   = 8'h55;
                valid[0] = 1'b1;
            end
            if (k == 4) valid[0] = 1'b0;
        end
        chk("busy_load_done_count", dcount, 32'd1);
        chk("busy_load_queue", qsize(0), 32'd0);

        // Reset during bit 3 of 8'hFF on A
        send(0, 8'hFF, 8'hFF);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        qa.delete();
        dcount = 0;
        @(negedge clk);
        chk("rst_mid_w_out",     {31'd0, wo[0]},  32'd0);
        chk("rst_mid_bit_valid", {31'd0, bv[0]},  32'd0);
        chk("rst_mid_last_bit",  {31'd0, lb[0]},  32'd0);
        chk("rst_mid_busy",      {31'd0, bz[0]},  32'd0);
        chk("rst_mid_ready",     {31'd0, rdy[0]}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (dn[0]) dcount++;
            @(negedge clk);
        end
        chk("rst_mid_no_done", dcount, 32'd0);
        send(0, 8'h81, 8'b10000001);
        wait_done(0);

        // Input stability: data_in scrambled every cycle after accept
        send(0, 8'hC3, 8'b11000011);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            din[0] = 8'($urandom);
        end
        wait_done(0);
        chk("stable_z_pairs", zc[0], 32'd2);

        repeat (3) @(negedge clk);
        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front end for the two-consecutive-ones detector stage. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on `w_out`, which drives the detector's `w` input directly. An optional run of forced-zero gap cycles follows each word so that ones from adjacent words never merge into a false pair downstream. Status strobes mark bit validity, the last bit, and word completion.

## Interface
Parameters:
- `WIDTH`, default 8: word length in bits; legal range ≥ 2.
- `GAP_CYCLES`, default 2: forced-zero cycles after each word; legal range ≥ 0.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  word to serialize; sampled only on an accepted load.
- `load_valid`  in  1  upstream offers `data_in`.
- `load_ready`  out  1  high only in IDLE; a load is accepted on an edge where `load_valid && load_ready`.
- `w_out`  out  1  serial bit to the detector; 0 whenever `bit_valid` = 0.
- `bit_valid`  out  1  `w_out` carries a data bit this cycle.
- `last_bit`  out  1  this cycle carries the final bit of the word.
- `done`  out  1  one-cycle pulse in the cycle after the last bit.
- `busy`  out  1  high in SHIFT or GAP.

## Operation
- FSM states: IDLE, SHIFT, GAP.
  - IDLE → SHIFT on an accepted load.
  - SHIFT → GAP after WIDTH bits when `GAP_CYCLES` > 0; otherwise SHIFT → IDLE.
  - GAP → IDLE after `GAP_CYCLES` cycles.
- On accept, `data_in` is copied into the shift register and the bit counter is cleared. Later changes to `data_in` have no effect.
- SHIFT: each cycle presents one bit and advances the shift register by one position in the direction set by `MSB_FIRST`.
- Bit counter: `$clog2(WIDTH)` bits wide, counts 0..WIDTH-1 with no wrap past WIDTH-1. `last_bit` = SHIFT && count == WIDTH-1.
- GAP counter: counts 0..GAP_CYCLES-1. It is omitted when `GAP_CYCLES` = 0.
- In IDLE and GAP: `w_out` = 0, `bit_valid` = 0.
- `load_valid` while `load_ready` = 0 is ignored. No queuing; upstream must hold `load_valid`.
- `busy` = (state != IDLE). `load_ready` = (state == IDLE).

## Timing
- Reset values, all forced on the reset edge: state IDLE, `w_out` 0, `bit_valid` 0, `last_bit` 0, `done` 0, `busy` 0, `load_ready` 1, counters 0.
- All outputs are registered except `load_ready` and `busy`, which decode the state register.
- Accept at edge N: first bit on `w_out` during cycle N+1. Bit k appears during cycle N+1+k. `last_bit` is high during cycle N+WIDTH.
- `done` is high during cycle N+WIDTH+1, whether that cycle is the first GAP cycle or IDLE.
- `load_ready` returns to 1 in cycle N+WIDTH+1+GAP_CYCLES. A load accepted on that edge starts a new word immediately.
- Minimum word period: WIDTH+GAP_CYCLES+1 cycles.
- `done` and a new accept may coincide when `GAP_CYCLES` = 0. Both take effect.
- Reset mid-word: the word is discarded. `w_out`, `bit_valid`, and `last_bit` are 0 and `load_ready` is 1 after the reset edge. No `done` is produced for the aborted word.
- `reset` takes priority over an accept on the same edge.

## Test plan
- Basic MSB-first (WIDTH=8, GAP=2): load 8'hB6 → `w_out` 1,0,1,1,0,1,1,0 on cycles N+1..N+8. `last_bit` high only on N+8, `done` on N+9, `w_out` 0 on N+9..N+10, `load_ready` 1 on N+11. The downstream detector's `z` is high only during the two cycles carrying the second 1 of each adjacent-ones pair (bits 5,4 and 2,1).
- LSB-first (MSB_FIRST=0): load 8'hB6 → `w_out` 0,1,1,0,1,1,0,1.
- Back-to-back with GAP=0: hold `load_valid` with 8'hFF then 8'h01. The second word's first bit appears on cycle N+10, and `done` and the second accept occur in the same cycle.
- Load while busy: pulse `load_valid` with 8'h55 during SHIFT of 8'hB6 → ignored. The serialized stream is 8'hB6 only and exactly one `done` is produced.
- Reset mid-word: assert `reset` on bit 3 of 8'hFF → next cycle `w_out` 0, `busy` 0, `load_ready` 1, no `done`. A following load of 8'h81 serializes as 1,0,0,0,0,0,0,1.
- Input stability: change `data_in` every cycle after accepting 8'hC3 → output is still 1,1,0,0,0,0,1,1.
